// File: rtl/pll_seq_ctrl.sv
// Control-side sequencer for a Gowin PLL wrapper: resets the PLL, filters lock,
// staggers the output clock enables and then releases the downstream reset.
module pll_seq_ctrl #(
  parameter int RST_HOLD     = 16,
  parameter int LOCK_FILTER  = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int EN_STAGGER   = 8,
  parameter int NUM_CLK      = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pll_lock,
  input  logic               relock_req,
  output logic               pll_reset,
  output logic [NUM_CLK-1:0] pll_enclk,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               err_timeout,
  output logic [7:0]         relock_cnt
);

  localparam int CNT_MAX_A = (RST_HOLD > LOCK_FILTER) ? RST_HOLD : LOCK_FILTER;
  localparam int CNT_MAX   = (CNT_MAX_A > EN_STAGGER) ? CNT_MAX_A : EN_STAGGER;
  localparam int CNT_W     = ($clog2(CNT_MAX + 1) > 17) ? $clog2(CNT_MAX + 1) : 17;
  localparam int TMO_W     = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    ENABLE    = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [2:0]         en_idx_q, en_idx_d;
  logic [NUM_CLK-1:0] enclk_q, enclk_d;
  logic               err_q, err_d;
  logic [7:0]         relock_q, relock_d;
  logic               lock_meta_q, lock_s_q;
  logic               arm_q;
  logic               pll_reset_q, sys_rst_n_q, ready_q;
  logic               lock_loss, timeout;

  always_comb begin
    state_d   = state_q;
    cnt_d     = arm_q ? cnt_q + CNT_W'(1) : cnt_q;
    tmo_d     = tmo_q;
    en_idx_d  = en_idx_q;
    enclk_d   = enclk_q;
    err_d     = err_q;
    relock_d  = relock_q;
    lock_loss = 1'b0;
    timeout   = 1'b0;

    case (state_q)
      HOLD: begin
        if (arm_q && cnt_q == CNT_W'(RST_HOLD - 1)) begin
          state_d = WAIT_LOCK;
          tmo_d   = '0;
        end
      end
      WAIT_LOCK: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) timeout = 1'b1;
        else if (lock_s_q)                    state_d = FILTER;
      end
      FILTER: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
          timeout = 1'b1;
        end else if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
          state_d  = ENABLE;
          en_idx_d = '0;
          enclk_d  = NUM_CLK'(1);
        end
      end
      ENABLE: begin
        if (!lock_s_q) begin
          lock_loss = 1'b1;
        end else if (cnt_q == CNT_W'(EN_STAGGER - 1)) begin
          // Restart the stagger interval after every enable step.
          cnt_d = '0;
          if (en_idx_q == 3'(NUM_CLK - 1)) begin
            state_d = RUN;
          end else begin
            en_idx_d = en_idx_q + 3'd1;
            enclk_d  = enclk_q | (NUM_CLK'(1) << en_idx_d);
          end
        end
      end
      RUN: begin
        if (!lock_s_q) lock_loss = 1'b1;
      end
      default: state_d = HOLD;
    endcase

    if (timeout) begin
      state_d = HOLD;
      err_d   = 1'b1;
    end
    if (lock_loss) begin
      state_d  = HOLD;
      relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
    end
    // A software restart overrides a coincident timeout and clears the flag.
    if (relock_req && state_q != HOLD) begin
      state_d = HOLD;
      err_d   = 1'b0;
    end

    if (state_d != state_q) cnt_d = '0;
    if (state_d == HOLD)    enclk_d = '0;
    if (state_d == RUN)     enclk_d = '1;
  end

  // arm_q holds off the HOLD counter for the first edge after reset release,
  // so HOLD spans RST_HOLD edges both after reset and after a restart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      tmo_q       <= '0;
      en_idx_q    <= '0;
      enclk_q     <= '0;
      err_q       <= 1'b0;
      relock_q    <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      arm_q       <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      en_idx_q    <= en_idx_d;
      enclk_q     <= enclk_d;
      err_q       <= err_d;
      relock_q    <= relock_d;
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      arm_q       <= 1'b1;
      pll_reset_q <= (state_d == HOLD);
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
    end
  end

  assign pll_reset   = pll_reset_q;
  assign pll_enclk   = enclk_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = ready_q;
  assign err_timeout = err_q;
  assign relock_cnt  = relock_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Scoreboard bench for pll_seq_ctrl: expected output snapshots are queued per
// edge number (edge 0 = first rising edge after reset release) and compared.
module tb_pll_seq_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_reset;
  logic [2:0] pll_enclk;
  logic       sys_rst_n;
  logic       ready;
  logic       err_timeout;
  logic [7:0] relock_cnt;

  pll_seq_ctrl #(
    .RST_HOLD(4), .LOCK_FILTER(8), .LOCK_TIMEOUT(100), .EN_STAGGER(2), .NUM_CLK(3)
  ) dut (
    .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .relock_req(relock_req),
    .pll_reset(pll_reset), .pll_enclk(pll_enclk), .sys_rst_n(sys_rst_n),
    .ready(ready), .err_timeout(err_timeout), .relock_cnt(relock_cnt)
  );

  always #5 clk = ~clk;

  int edge_no = -1;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) edge_no <= -1;
    else         edge_no <= edge_no + 1;
  end

  typedef struct {
    int          cyc;
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s @edge %0d: got %0h want %0h", tag, edge_no, got, want);
    end
  endtask

  function automatic logic [31:0] vec(input logic r, input logic [2:0] e, input logic s,
                                      input logic rd, input logic er, input int rc);
    return {17'd0, r, e, s, rd, er, 8'(rc)};
  endfunction

  function automatic logic [31:0] obs();
    return {17'd0, pll_reset, pll_enclk, sys_rst_n, ready, err_timeout, relock_cnt};
  endfunction

  task automatic push(input int c, input string t, input logic [31:0] e);
    sb_t x;
    x.cyc = c; x.tag = t; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic sb_drain();
    sb_t e;
    while (sb.size() > 0 && sb[0].cyc <= edge_no) begin
      e = sb.pop_front();
      if (e.cyc == edge_no) chk(e.tag, obs(), e.exp);
      else                  chk({e.tag, "_missed"}, 32'(edge_no), 32'(e.cyc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    sb_drain();
  endtask

  task automatic wait_edge(input int m);
    int n;
    n = 0;
    while (edge_no < m && n < 2000) begin
      tick();
      n++;
    end
    if (edge_no < m) chk("wait_edge", 32'(edge_no), 32'(m));
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      tick();
      n++;
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic apply_reset();
    resetn     = 1'b0;
    pll_lock   = 1'b0;
    relock_req = 1'b0;
    tick();
    tick();
    push(-1, "rst_vals", vec(1, 3'b000, 0, 0, 0, 0));
    tick();
    resetn = 1'b1;
  endtask

  // Lock rises before edge 10; stop after edge 22 unless full.
  task automatic clean_start(input bit full);
    apply_reset();
    push(3, "s1_hold", vec(1, 3'b000, 0, 0, 0, 0));
    push(4, "s1_rel",  vec(0, 3'b000, 0, 0, 0, 0));
    wait_edge(9);
    pll_lock = 1'b1;
    push(19, "s1_pre",  vec(0, 3'b000, 0, 0, 0, 0));
    push(20, "s1_en0",  vec(0, 3'b001, 0, 0, 0, 0));
    push(21, "s1_en0b", vec(0, 3'b001, 0, 0, 0, 0));
    push(22, "s1_en1",  vec(0, 3'b011, 0, 0, 0, 0));
    if (full) begin
      push(24, "s1_en2", vec(0, 3'b111, 0, 0, 0, 0));
      push(25, "s1_pre_run", vec(0, 3'b111, 0, 0, 0, 0));
      push(26, "s1_run", vec(0, 3'b111, 1, 1, 0, 0));
    end
    drain_all();
  endtask

  initial begin
    // Clean start.
    clean_start(1);

    // Glitchy lock: filter entered at 8, aborted at 13, re-entered at 14.
    apply_reset();
    push(4, "s2_rel", vec(0, 3'b000, 0, 0, 0, 0));
    wait_edge(5);
    pll_lock = 1'b1;
    wait_edge(10);
    pll_lock = 1'b0;
    wait_edge(11);
    pll_lock = 1'b1;
    push(16, "s2_noearly", vec(0, 3'b000, 0, 0, 0, 0));
    push(21, "s2_pre",     vec(0, 3'b000, 0, 0, 0, 0));
    push(22, "s2_en0",     vec(0, 3'b001, 0, 0, 0, 0));
    push(24, "s2_en1",     vec(0, 3'b011, 0, 0, 0, 0));
    push(26, "s2_en2",     vec(0, 3'b111, 0, 0, 0, 0));
    push(28, "s2_run",     vec(0, 3'b111, 1, 1, 0, 0));
    drain_all();

    // Timeout with lock held low, then a retry that reaches RUN.
    apply_reset();
    push(4,   "s3_rel",   vec(0, 3'b000, 0, 0, 0, 0));
    push(103, "s3_pre",   vec(0, 3'b000, 0, 0, 0, 0));
    push(104, "s3_tmo",   vec(1, 3'b000, 0, 0, 1, 0));
    push(107, "s3_hold",  vec(1, 3'b000, 0, 0, 1, 0));
    push(108, "s3_rel2",  vec(0, 3'b000, 0, 0, 1, 0));
    drain_all();
    wait_edge(110);
    pll_lock = 1'b1;
    push(121, "s5_en0",   vec(0, 3'b001, 0, 0, 1, 0));
    push(127, "s5_run",   vec(0, 3'b111, 1, 1, 1, 0));
    push(130, "s5_run2",  vec(0, 3'b111, 1, 1, 1, 0));
    wait_edge(130);
    // relock_req in RUN with err_timeout set.
    relock_req = 1'b1;
    push(131, "s5_req",   vec(1, 3'b000, 0, 0, 0, 0));
    wait_edge(131);
    relock_req = 1'b0;
    wait_edge(132);
    // relock_req is ignored while already in HOLD.
    relock_req = 1'b1;
    wait_edge(133);
    relock_req = 1'b0;
    push(134, "s5_hold",  vec(1, 3'b000, 0, 0, 0, 0));
    push(135, "s5_rel",   vec(0, 3'b000, 0, 0, 0, 0));
    push(143, "s5_pre",   vec(0, 3'b000, 0, 0, 0, 0));
    push(144, "s5_en0",   vec(0, 3'b001, 0, 0, 0, 0));
    drain_all();

    // Repeated lock loss in RUN; counter saturates at 255.
    clean_start(1);
    for (int i = 1; i <= 300; i++) begin
      int h, rc, rc_prev;
      h       = edge_no + 3;
      rc      = (i > 255) ? 255 : i;
      rc_prev = (i - 1 > 255) ? 255 : i - 1;
      pll_lock = 1'b0;
      push(h - 1, "s4_run",  vec(0, 3'b111, 1, 1, 0, rc_prev));
      push(h,     "s4_drop", vec(1, 3'b000, 0, 0, 0, rc));
      wait_edge(h + 6);
      pll_lock = 1'b1;
      push(h + 17, "s4_en0",  vec(0, 3'b001, 0, 0, 0, rc));
      push(h + 23, "s4_rerun", vec(0, 3'b111, 1, 1, 0, rc));
      drain_all();
    end

    // Asynchronous reset mid-ENABLE, then an identical restart.
    clean_start(0);
    #2;
    resetn = 1'b0;
    #1;
    push(-1, "s6_async", vec(1, 3'b000, 0, 0, 0, 0));
    sb_drain();
    clean_start(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
